// File: rtl/score_timer.sv
// score_timer: BCD score/countdown bookkeeping with READY/PLAY/OVER game FSM
module score_timer #(
    parameter logic [15:0] COIN_PTS       = 16'h0010,
    parameter logic [15:0] STOMP_PTS      = 16'h0100,
    parameter logic [7:0]  TIME_START     = 8'h99,
    parameter int          FRAMES_PER_SEC = 60
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start,
    input  logic        coin_alive,
    input  logic        gomba_dead,
    input  logic        mario_dead,
    input  logic        luigi_dead,
    output logic [23:0] score_digits,
    output logic        game_over,
    output logic        playing
);
    localparam int FW = FRAMES_PER_SEC > 1 ? $clog2(FRAMES_PER_SEC) : 1;
    typedef enum logic [1:0] {READY, PLAY, OVER} state_t;
    state_t state, state_n;
    logic frame_prev, coin_prev, gomba_prev, stomp_pend, pend_n;
    logic frame_ev, coin_ev, stomp_ev, both_dead, sec_tick, add_stomp, entry, carry;
    logic [15:0] score, score_n, addend, sum;
    logic [7:0] timer, timer_n, timer_dec;
    logic [FW-1:0] fcnt, fcnt_n;
    assign frame_ev  = frame_clk & ~frame_prev;
    assign coin_ev   = ~coin_alive & coin_prev;
    assign stomp_ev  = gomba_dead & ~gomba_prev;
    assign both_dead = mario_dead & luigi_dead;
    assign sec_tick  = frame_ev && fcnt == FW'(FRAMES_PER_SEC - 1);
    assign add_stomp = ~coin_ev & (stomp_ev | stomp_pend);
    assign addend    = coin_ev ? COIN_PTS : add_stomp ? STOMP_PTS : 16'h0000;
    assign timer_dec = timer[3:0] == 4'd0 ? {timer[7:4] == 4'd0 ? 4'd9 : timer[7:4] - 4'd1, 4'd9}
                                          : {timer[7:4], timer[3:0] - 4'd1};
    assign score_digits = {timer, score};
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= READY;
        else       state <= state_n;
    end
    always_comb begin
        state_n = state == PLAY ? ((both_dead || (sec_tick && timer == 8'h01)) ? OVER : PLAY)
                                : (start ? PLAY : state);
    end
    always_comb begin
        game_over = state == OVER;
        playing   = state == PLAY;
    end
    always_comb begin
        logic [4:0] d;
        sum   = '0;
        carry = 1'b0;
        d     = '0;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, score[4*i +: 4]} + {1'b0, addend[4*i +: 4]} + {4'd0, carry};
            carry = d > 5'd9;
            sum[4*i +: 4] = carry ? d[3:0] + 4'd6 : d[3:0];
        end
    end
    always_comb begin
        entry   = state != PLAY && state_n == PLAY;
        score_n = entry ? 16'h0000 : state == PLAY ? (carry ? 16'h9999 : sum) : score;
        timer_n = entry ? TIME_START : (state == PLAY && sec_tick && !both_dead) ? timer_dec : timer;
        fcnt_n  = entry ? '0 : (state == PLAY && frame_ev) ? (sec_tick ? '0 : fcnt + FW'(1)) : fcnt;
        pend_n  = !entry && state == PLAY && coin_ev && (stomp_pend || stomp_ev);
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_prev <= 1'b0;
            coin_prev  <= 1'b0;
            gomba_prev <= 1'b0;
            stomp_pend <= 1'b0;
            score      <= 16'h0000;
            timer      <= TIME_START;
            fcnt       <= '0;
        end else begin
            frame_prev <= frame_clk;
            coin_prev  <= coin_alive;
            gomba_prev <= gomba_dead;
            stomp_pend <= pend_n;
            score      <= score_n;
            timer      <= timer_n;
            fcnt       <= fcnt_n;
        end
    end
endmodule

// File: tb/tb_score_timer.sv
// tb_score_timer: directed checks of scoring, saturation, timer expiry and game FSM
module tb_score_timer;
    logic clk = 1'b0, rst = 1'b1;
    logic frame_clk = 1'b0, start = 1'b0, coin_alive = 1'b1, gomba_dead = 1'b0;
    logic mario_dead = 1'b0, luigi_dead = 1'b0;
    logic [23:0] digits, digits2;
    logic over, play, over2, play2;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    score_timer u1 (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .start(start), .coin_alive(coin_alive),
        .gomba_dead(gomba_dead), .mario_dead(mario_dead), .luigi_dead(luigi_dead),
        .score_digits(digits), .game_over(over), .playing(play)
    );

    score_timer #(.TIME_START(8'h02), .FRAMES_PER_SEC(2)) u2 (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .start(start), .coin_alive(coin_alive),
        .gomba_dead(gomba_dead), .mario_dead(mario_dead), .luigi_dead(luigi_dead),
        .score_digits(digits2), .game_over(over2), .playing(play2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (digits !== 24'h990000) begin errors++; $display("FAIL reset_digits got %h exp 990000", digits); end
        checks++; if ({over, play} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {over, play}); end
        checks++; if (digits2 !== 24'h020000) begin errors++; $display("FAIL reset_digits2 got %h exp 020000", digits2); end
        @(negedge clk);
        rst = 1'b0;
        coin_alive = 1'b0;
        tick();
        checks++; if (digits !== 24'h990000 || play !== 1'b0) begin errors++; $display("FAIL ready_ignore got %h/%b exp 990000/0", digits, play); end
        coin_alive = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (play !== 1'b1 || over !== 1'b0) begin errors++; $display("FAIL start_play got %b%b exp 01", over, play); end
        checks++; if (digits !== 24'h990000) begin errors++; $display("FAIL start_digits got %h exp 990000", digits); end
    endtask

    task automatic test_coin();
        coin_alive = 1'b0;
        tick();
        checks++; if (digits !== 24'h990010) begin errors++; $display("FAIL coin_fall got %h exp 990010", digits); end
        coin_alive = 1'b1;
        tick();
        checks++; if (digits !== 24'h990010) begin errors++; $display("FAIL coin_rise got %h exp 990010", digits); end
    endtask

    task automatic test_back_to_back();
        coin_alive = 1'b0;
        gomba_dead = 1'b1;
        tick();
        checks++; if (digits !== 24'h990020) begin errors++; $display("FAIL b2b_k got %h exp 990020", digits); end
        coin_alive = 1'b1;
        gomba_dead = 1'b0;
        tick();
        checks++; if (digits !== 24'h990120) begin errors++; $display("FAIL b2b_k1 got %h exp 990120", digits); end
        tick();
        checks++; if (digits !== 24'h990120) begin errors++; $display("FAIL b2b_hold got %h exp 990120", digits); end
    endtask

    task automatic test_dead();
        mario_dead = 1'b1;
        tick();
        checks++; if (play !== 1'b1 || over !== 1'b0) begin errors++; $display("FAIL one_dead got %b%b exp 01", over, play); end
        luigi_dead = 1'b1;
        tick();
        checks++; if (over !== 1'b1 || play !== 1'b0) begin errors++; $display("FAIL both_dead got %b%b exp 10", over, play); end
        mario_dead = 1'b0;
        luigi_dead = 1'b0;
        coin_alive = 1'b0;
        tick();
        checks++; if (digits !== 24'h990120) begin errors++; $display("FAIL over_frozen got %h exp 990120", digits); end
        coin_alive = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (digits !== 24'h990000 || play !== 1'b1) begin errors++; $display("FAIL restart got %h/%b exp 990000/1", digits, play); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 999; i++) begin
            coin_alive = 1'b0;
            tick();
            coin_alive = 1'b1;
            tick();
            if (i == 9) begin
                checks++; if (digits !== 24'h990100) begin errors++; $display("FAIL bcd_carry got %h exp 990100", digits); end
            end
        end
        checks++; if (digits !== 24'h999990) begin errors++; $display("FAIL preset got %h exp 999990", digits); end
        gomba_dead = 1'b1;
        tick();
        gomba_dead = 1'b0;
        checks++; if (digits !== 24'h999999) begin errors++; $display("FAIL saturate got %h exp 999999", digits); end
        tick();
        coin_alive = 1'b0;
        tick();
        coin_alive = 1'b1;
        checks++; if (digits !== 24'h999999) begin errors++; $display("FAIL sat_hold got %h exp 999999", digits); end
    endtask

    task automatic test_timer();
        logic [23:0] exp_t [4];
        exp_t[0] = 24'h020000; exp_t[1] = 24'h010000; exp_t[2] = 24'h010000; exp_t[3] = 24'h000000;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (digits2 !== 24'h020000 || play2 !== 1'b1) begin errors++; $display("FAIL t_start got %h/%b exp 020000/1", digits2, play2); end
        for (int e = 0; e < 4; e++) begin
            frame_clk = 1'b1;
            tick();
            checks++; if (digits2 !== exp_t[e]) begin errors++; $display("FAIL frame%0d got %h exp %h", e + 1, digits2, exp_t[e]); end
            if (e == 3) begin
                checks++; if (over2 !== 1'b1 || play2 !== 1'b0) begin errors++; $display("FAIL expire got %b%b exp 10", over2, play2); end
            end else begin
                checks++; if (over2 !== 1'b0) begin errors++; $display("FAIL early_over frame%0d got %b exp 0", e + 1, over2); end
            end
            frame_clk = 1'b0;
            tick();
        end
        checks++; if (digits !== 24'h990000) begin errors++; $display("FAIL slow_timer got %h exp 990000", digits); end
        coin_alive = 1'b0;
        tick();
        coin_alive = 1'b1;
        checks++; if (digits2 !== 24'h000000) begin errors++; $display("FAIL over_coin got %h exp 000000", digits2); end
        checks++; if (digits !== 24'h990010) begin errors++; $display("FAIL play_coin got %h exp 990010", digits); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        #2;
        checks++; if (digits !== 24'h990000 || {over, play} !== 2'b00) begin errors++; $display("FAIL async_rst got %h/%b exp 990000/00", digits, {over, play}); end
        checks++; if (digits2 !== 24'h020000 || {over2, play2} !== 2'b00) begin errors++; $display("FAIL async_rst2 got %h/%b exp 020000/00", digits2, {over2, play2}); end
        rst = 1'b0;
        tick();
        tick();
        checks++; if (play !== 1'b0 || digits !== 24'h990000) begin errors++; $display("FAIL no_resume got %h/%b exp 990000/0", digits, play); end
    endtask

    initial begin
        test_reset();
        test_coin();
        test_back_to_back();
        test_dead();
        test_saturate();
        test_timer();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
